// File: rtl/qoi_decoder.sv
`default_nettype none
// =============================================================================
// Module   : qoi_decoder
// Purpose  : Streaming QOI chunk decoder, encoded bytes in, RGBA pixels out.
//            Build option QOI_DEC_STD_INIT_EN: prev pixel starts opaque black.
// Revision : 1.0
// =============================================================================
module qoi_decoder #(
    parameter int SIZE_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE_W-1:0] size,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       px_o,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SIZE_W-1:0] count
);

`ifdef QOI_DEC_STD_INIT_EN
    localparam logic [31:0] c_prev_init = 32'hFF00_0000;
`else
    localparam logic [31:0] c_prev_init = 32'h0000_0000;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OP   = 3'd1,
        ARG  = 3'd2,
        EMIT = 3'd3,
        RUN  = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       prev_q, prev_d;
    logic [31:0]       px_q, px_d;
    logic [5:0]        run_q, run_d;
    logic [2:0]        argc_q, argc_d;
    logic [7:0]        op_q, op_d;
    logic [31:0]       index_q [64];
    logic [31:0]       index_d [64];

    logic [5:0]        w_hash;
    logic [SIZE_W-1:0] w_count_inc;
    logic              w_last;
    logic [7:0]        w_luma_dg;
    logic [2:0]        w_arg_last;

    assign in_ready = (state_q == OP) || (state_q == ARG);
    assign px_valid = (state_q == EMIT) || (state_q == RUN);
    assign busy     = (state_q != IDLE) && (state_q != FIN);
    assign px_o     = px_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

    // Index slot hash; only the low 6 bits of each channel affect a mod-64 sum.
    assign w_hash      = px_q[5:0] * 6'd3 + px_q[13:8] * 6'd5
                       + px_q[21:16] * 6'd7 + px_q[29:24] * 6'd11;
    assign w_count_inc = count_q + 1'b1;
    assign w_last      = (w_count_inc == size_q);
    assign w_luma_dg   = {2'b00, op_q[5:0]} - 8'd32;
    assign w_arg_last  = op_q[0] ? 3'd3 : 3'd2;

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;
        prev_d  = prev_q;
        px_d    = px_q;
        run_d   = run_q;
        argc_d  = argc_q;
        op_d    = op_q;
        for (int i = 0; i < 64; i++) index_d[i] = index_q[i];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    size_d  = size;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    prev_d  = c_prev_init;
                    for (int i = 0; i < 64; i++) index_d[i] = '0;
                    if (size == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = OP;
                    end
                end
            end
            OP: begin
                if (in_valid) begin
                    op_d   = in_data;
                    argc_d = 3'd0;
                    unique case (in_data[7:6])
                        2'b00: begin
                            px_d    = index_q[in_data[5:0]];
                            state_d = EMIT;
                        end
                        2'b01: begin
                            px_d[7:0]   = prev_q[7:0]   + {6'b0, in_data[5:4]} - 8'd2;
                            px_d[15:8]  = prev_q[15:8]  + {6'b0, in_data[3:2]} - 8'd2;
                            px_d[23:16] = prev_q[23:16] + {6'b0, in_data[1:0]} - 8'd2;
                            px_d[31:24] = prev_q[31:24];
                            state_d     = EMIT;
                        end
                        2'b10: state_d = ARG;
                        default: begin
                            px_d = prev_q;
                            if (in_data[5:1] == 5'h1F) begin
                                state_d = ARG;
                            end else begin
                                run_d   = in_data[5:0] + 6'd1;
                                state_d = RUN;
                            end
                        end
                    endcase
                end
            end
            ARG: begin
                if (in_valid) begin
                    if (op_q[7:6] == 2'b10) begin
                        px_d[7:0]   = prev_q[7:0] + w_luma_dg + {4'b0, in_data[7:4]} - 8'd8;
                        px_d[15:8]  = prev_q[15:8] + w_luma_dg;
                        px_d[23:16] = prev_q[23:16] + w_luma_dg + {4'b0, in_data[3:0]} - 8'd8;
                        px_d[31:24] = prev_q[31:24];
                        state_d     = EMIT;
                    end else begin
                        px_d[{argc_q[1:0], 3'b000} +: 8] = in_data;
                        if (argc_q == w_arg_last) state_d = EMIT;
                        else                      argc_d  = argc_q + 3'd1;
                    end
                end
            end
            EMIT: begin
                if (px_ready) begin
                    prev_d          = px_q;
                    index_d[w_hash] = px_q;
                    count_d         = w_count_inc;
                    if (w_last) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = OP;
                    end
                end
            end
            RUN: begin
                if (px_ready) begin
                    count_d = w_count_inc;
                    run_d   = run_q - 6'd1;
                    if (w_last) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        // Pixels left in the run cannot be delivered.
                        if (run_q > 6'd1) err_d = 1'b1;
                    end else if (run_q == 6'd1) begin
                        state_d = OP;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            prev_q  <= '0;
            px_q    <= '0;
            run_q   <= '0;
            argc_q  <= '0;
            op_q    <= '0;
            for (int i = 0; i < 64; i++) index_q[i] <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            prev_q  <= prev_d;
            px_q    <= px_d;
            run_q   <= run_d;
            argc_q  <= argc_d;
            op_q    <= op_d;
            for (int i = 0; i < 64; i++) index_q[i] <= index_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qoi_decoder.sv
`default_nettype none
// =============================================================================
// Module   : tb_qoi_decoder
// Purpose  : Self-checking bench for qoi_decoder with a behavioural QOI model.
// Revision : 1.0
// =============================================================================
module tb_qoi_decoder;
    localparam int SIZE_W = 30;
`ifdef QOI_DEC_STD_INIT_EN
    localparam logic [31:0] PREV_INIT = 32'hFF00_0000;
`else
    localparam logic [31:0] PREV_INIT = 32'h0000_0000;
`endif
    localparam logic [31:0] PI_A = PREV_INIT & 32'hFF00_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [SIZE_W-1:0] size = '0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       px_o;
    logic              px_valid;
    logic              px_ready = 1'b0;
    logic              busy, done, err;
    logic [SIZE_W-1:0] count;

    always #5 clk = ~clk;

    qoi_decoder #(.SIZE_W(SIZE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .px_o(px_o), .px_valid(px_valid), .px_ready(px_ready),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0]  in_bytes[$];
    logic [31:0] lit_px[$];
    logic [31:0] model_px[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Decode the byte list from the format rules alone.
    task automatic model(input int sz, output logic merr, output int used);
        logic [31:0] idx [64];
        logic [31:0] prev, px;
        logic [7:0]  b, r, g, bl, a, dg;
        int n, pos, len;
        for (int i = 0; i < 64; i++) idx[i] = '0;
        prev = PREV_INIT;
        model_px.delete();
        merr = 1'b0;
        n = 0;
        pos = 0;
        while (n < sz && pos < in_bytes.size()) begin
            b = in_bytes[pos];
            pos++;
            if (b == 8'hFE || b == 8'hFF) begin
                r  = in_bytes[pos];
                g  = in_bytes[pos+1];
                bl = in_bytes[pos+2];
                a  = (b == 8'hFF) ? in_bytes[pos+3] : prev[31:24];
                pos += (b == 8'hFF) ? 4 : 3;
                px = {a, bl, g, r};
            end else if (b >= 8'hC0) begin
                len = int'(b - 8'hC0) + 1;
                if (len > sz - n) begin
                    merr = 1'b1;
                    len = sz - n;
                end
                repeat (len) model_px.push_back(prev);
                n += len;
                continue;
            end else if (b >= 8'h80) begin
                dg = b - 8'hA0;
                a  = in_bytes[pos];
                pos++;
                r  = prev[7:0]   + dg + (a >> 4) - 8'd8;
                g  = prev[15:8]  + dg;
                bl = prev[23:16] + dg + (a & 8'h0F) - 8'd8;
                px = {prev[31:24], bl, g, r};
            end else if (b >= 8'h40) begin
                r  = prev[7:0]   + ((b >> 4) & 8'd3) - 8'd2;
                g  = prev[15:8]  + ((b >> 2) & 8'd3) - 8'd2;
                bl = prev[23:16] + (b & 8'd3) - 8'd2;
                px = {prev[31:24], bl, g, r};
            end else begin
                px = idx[b[5:0]];
            end
            model_px.push_back(px);
            prev = px;
            idx[(int'(px[7:0]) * 3 + int'(px[15:8]) * 5 + int'(px[23:16]) * 7
                 + int'(px[31:24]) * 11) % 64] = px;
            n++;
        end
        used = pos;
    endtask

    // Pixel compare and protocol monitor.
    logic        hold_pend = 1'b0;
    logic [31:0] hold_px = '0;
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("px_hold", {31'b0, px_valid, px_o}, {31'b0, 1'b1, hold_px});
            hold_pend = px_valid && !px_ready;
            hold_px   = px_o;
            if (px_valid && px_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL px_extra: got %h, no pixel required", px_o);
                end else begin
                    chk("px", px_o, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            if (busy) chk("in_ready_during_px", in_ready && px_valid, 0);
        end
    end

    task automatic run_case(input int sz, input bit toggle, input bit lit_err);
        logic merr;
        int mused, used, cyc, acc_cnt;
        bit acc, finished;
        model(sz, merr, mused);
        chk("model_len", model_px.size(), lit_px.size());
        for (int i = 0; i < lit_px.size() && i < model_px.size(); i++)
            chk("model_px", model_px[i], lit_px[i]);
        chk("model_err", merr, lit_err);
        exp_q = model_px;
        @(posedge clk); #1;
        size = sz[SIZE_W-1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_in_ready_after_start", {busy, in_ready}, 2'b11);
        used = 0;
        cyc = 0;
        finished = 0;
        while (!finished && cyc < 500) begin
            in_valid = (in_bytes.size() > 0);
            in_data  = in_valid ? in_bytes[0] : 8'h00;
            px_ready = toggle ? cyc[0] : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            finished = done;
            @(posedge clk); #1;
            if (acc) begin
                void'(in_bytes.pop_front());
                used++;
            end
            cyc++;
        end
        chk("done_timeout", finished, 1);
        chk("count", count, sz);
        chk("done", done, 1);
        chk("err", err, merr);
        chk("bytes_used", used, mused);
        chk("pixels_left", exp_q.size(), 0);
        chk("busy_idle", busy, 0);
        in_valid = 1'b1;
        in_data  = 8'hFE;
        acc_cnt  = 0;
        repeat (4) begin
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
        end
        chk("no_byte_after_done", acc_cnt, 0);
        in_valid = 1'b0;
    endtask

    task automatic reset_case();
        int cyc, acc_cnt;
        bit hit;
        in_bytes = {8'hFE, 8'h01, 8'h02, 8'h03, 8'hC9};
        exp_q    = {PI_A | 32'h0003_0201, PI_A | 32'h0003_0201, PI_A | 32'h0003_0201};
        @(posedge clk); #1;
        size = 30'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        px_ready = 1'b1;
        cyc = 0;
        hit = 0;
        while (!hit && cyc < 100) begin
            in_valid = (in_bytes.size() > 0);
            in_data  = in_valid ? in_bytes[0] : 8'h00;
            @(negedge clk);
            if (count == 30'd2 && px_valid) begin
                rst = 1'b1;
                hit = 1;
            end else begin
                if (in_valid && in_ready) void'(in_bytes.pop_front());
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("reach_second_run_px", hit, 1);
        @(posedge clk); #1;
        chk("rst_flags", {in_ready, px_valid, busy, done, err}, 5'b0);
        chk("rst_px_o", px_o, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        exp_q.delete();
        in_valid = 1'b1;
        in_data  = 8'h40;
        size     = '0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("size0_done", {done, busy}, 2'b10);
        acc_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
        end
        chk("size0_no_byte", acc_cnt, 0);
        chk("size0_count", count, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {in_ready, px_valid, busy, done, err}, 5'b0);
        chk("reset_px_o", px_o, 0);
        chk("reset_count", count, 0);
        rst = 1'b0;

        in_bytes = {8'hFE, 8'h0A, 8'h14, 8'h1E};
        lit_px   = {PI_A | 32'h001E_140A};
        run_case(1, 0, 0);

        in_bytes = {8'hFF, 8'h10, 8'h20, 8'h30, 8'hFF, 8'h79};
        lit_px   = {32'hFF30_2010, 32'hFF2F_2011};
        run_case(2, 0, 0);

        in_bytes = {8'hFF, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hA8, 8'h97};
        lit_px   = {32'hFF30_2010, 32'hFF37_2819};
        run_case(2, 0, 0);

        in_bytes = {8'hFF, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00,
                    8'h17, 8'hC2, 8'hC0};
        lit_px   = {32'hFF03_0201, 32'hFF00_0000, 32'hFF03_0201, 32'hFF03_0201,
                    32'hFF03_0201, 32'hFF03_0201, 32'hFF03_0201};
        run_case(7, 1, 0);

        in_bytes = {8'h40, 8'h00};
        lit_px   = {PI_A | 32'h00FE_FEFE, 32'h0000_0000};
        run_case(2, 1, 0);

        in_bytes = {8'hFE, 8'h01, 8'h01, 8'h01, 8'hC9};
        lit_px   = {PI_A | 32'h0001_0101, PI_A | 32'h0001_0101, PI_A | 32'h0001_0101};
        run_case(3, 0, 1);

        reset_case();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
